// File: rtl/pc_update.sv
// pc_update: writer end of the program-counter path.
// Holds the architectural PC, chooses the next PC from sequential increment
// or a redirect (exception, jump, branch), and commits each new PC into the
// file register through its write port so fetch can read it back.

module pc_update #(
   parameter logic [31:0] RESET_PC         = 32'h00000000,
   parameter logic [31:0] EXCEPTION_VECTOR = 32'h00000080,
   parameter logic [4:0]  PC_REG_INDEX     = 5'd0,
   parameter logic [31:0] INCREMENT        = 32'd4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        exception,
   output logic        write_enable,
   output logic [4:0]  write_index,
   output logic [31:0] write_value,
   output logic [31:0] pc,
   output logic        fetch_valid,
   output logic        flush,
   output logic        misaligned
);

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2,
      FLUSH = 2'd3
   } state_t;

   state_t      state;
   state_t      next_state;

   logic        redirect;
   logic [31:0] raw_target;
   logic [31:0] aligned_target;
   logic        target_misaligned;
   logic [31:0] sequential_pc;

   logic [31:0] next_pc;
   logic        next_fetch_valid;
   logic        next_flush;
   logic        next_misaligned;
   logic        force_write;
   logic        commit;

   // The PC always lives at one fixed file-register slot.
   assign write_index = PC_REG_INDEX;

   // Pick the highest-priority redirect target and align it; only jump and
   // branch targets can report misalignment, the exception vector never does.
   always_comb begin
      redirect          = exception | jump | branch_taken;
      raw_target        = branch_target;
      target_misaligned = 1'b0;
      if (exception) begin
         raw_target = EXCEPTION_VECTOR;
      end else if (jump) begin
         raw_target        = jump_target;
         target_misaligned = (jump_target[1:0] != 2'b00);
      end else if (branch_taken) begin
         raw_target        = branch_target;
         target_misaligned = (branch_target[1:0] != 2'b00);
      end
      aligned_target = {raw_target[31:2], 2'b00};
      sequential_pc  = pc + INCREMENT;
   end

   // Next-state and next-output selection; a redirect always beats stall,
   // and lower-priority events in the same cycle are simply dropped.
   always_comb begin
      next_state       = state;
      next_pc          = pc;
      next_fetch_valid = fetch_valid;
      next_flush       = 1'b0;
      next_misaligned  = 1'b0;
      force_write      = 1'b0;
      case (state)
         INIT: begin
            next_state       = RUN;
            next_fetch_valid = 1'b0;
            force_write      = 1'b1;
         end
         RUN, STALL: begin
            if (redirect) begin
               next_pc          = aligned_target;
               next_flush       = 1'b1;
               next_misaligned  = target_misaligned;
               next_fetch_valid = 1'b0;
               next_state       = FLUSH;
            end else if (stall) begin
               next_fetch_valid = 1'b1;
               next_state       = STALL;
            end else begin
               next_pc          = sequential_pc;
               next_fetch_valid = 1'b1;
               next_state       = RUN;
            end
         end
         FLUSH: begin
            if (redirect) begin
               next_pc          = aligned_target;
               next_flush       = 1'b1;
               next_misaligned  = target_misaligned;
               next_fetch_valid = 1'b0;
               next_state       = FLUSH;
            end else begin
               next_fetch_valid = 1'b1;
               next_state       = RUN;
            end
         end
         default: begin
            next_state = INIT;
         end
      endcase
      commit = force_write | (next_pc != pc);
   end

   // Register state and every output; write_value only moves on a commit.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= INIT;
         pc           <= RESET_PC;
         write_enable <= 1'b0;
         write_value  <= 32'h00000000;
         fetch_valid  <= 1'b0;
         flush        <= 1'b0;
         misaligned   <= 1'b0;
      end else begin
         state        <= next_state;
         pc           <= next_pc;
         write_enable <= commit;
         if (commit) begin
            write_value <= next_pc;
         end
         fetch_valid  <= next_fetch_valid;
         flush        <= next_flush;
         misaligned   <= next_misaligned;
      end
   end

endmodule

// File: tb/tb_pc_update.sv
// tb_pc_update: directed stimulus with hand-computed expectations for pc_update.

module tb_pc_update;

   logic        clock;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        exception;
   logic        write_enable;
   logic [4:0]  write_index;
   logic [31:0] write_value;
   logic [31:0] pc;
   logic        fetch_valid;
   logic        flush;
   logic        misaligned;

   int compared;
   int mismatched;

   pc_update dut (
      .clock        (clock),
      .reset        (reset),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .jump         (jump),
      .jump_target  (jump_target),
      .exception    (exception),
      .write_enable (write_enable),
      .write_index  (write_index),
      .write_value  (write_value),
      .pc           (pc),
      .fetch_valid  (fetch_valid),
      .flush        (flush),
      .misaligned   (misaligned)
   );

   // Free-running clock, period 10.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and settle before sampling.
   task automatic applyStimulus();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Compare the full observable output set in one call.
   task automatic checkAll(input string tag, input logic [31:0] exp_pc, input logic exp_we,
                           input logic [31:0] exp_wv, input logic exp_fv, input logic exp_flush,
                           input logic exp_mis);
      checkOutput({tag, ".pc"}, pc, exp_pc);
      checkOutput({tag, ".we"}, {31'd0, write_enable}, {31'd0, exp_we});
      checkOutput({tag, ".wv"}, write_value, exp_wv);
      checkOutput({tag, ".fv"}, {31'd0, fetch_valid}, {31'd0, exp_fv});
      checkOutput({tag, ".flush"}, {31'd0, flush}, {31'd0, exp_flush});
      checkOutput({tag, ".mis"}, {31'd0, misaligned}, {31'd0, exp_mis});
      checkOutput({tag, ".wi"}, {27'd0, write_index}, 32'd0);
   endtask

   initial begin
      compared      = 0;
      mismatched    = 0;
      reset         = 1'b1;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 32'h0;
      jump          = 1'b0;
      jump_target   = 32'h0;
      exception     = 1'b0;

      // Reset state
      applyStimulus();
      checkAll("reset", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

      // INIT cycle commits RESET_PC, then sequential increment
      reset = 1'b0;
      applyStimulus();
      checkAll("init", 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
      applyStimulus();
      checkAll("seq4", 32'h4, 1'b1, 32'h4, 1'b1, 1'b0, 1'b0);
      applyStimulus();
      checkAll("seq8", 32'h8, 1'b1, 32'h8, 1'b1, 1'b0, 1'b0);
      applyStimulus();
      checkAll("seqC", 32'hC, 1'b1, 32'hC, 1'b1, 1'b0, 1'b0);
      applyStimulus();
      checkAll("seq10", 32'h10, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0);

      // Stall held for three cycles at 0x10
      stall = 1'b1;
      applyStimulus();
      checkAll("stall1", 32'h10, 1'b0, 32'h10, 1'b1, 1'b0, 1'b0);
      applyStimulus();
      checkAll("stall2", 32'h10, 1'b0, 32'h10, 1'b1, 1'b0, 1'b0);
      applyStimulus();
      checkAll("stall3", 32'h10, 1'b0, 32'h10, 1'b1, 1'b0, 1'b0);
      stall = 1'b0;
      applyStimulus();
      checkAll("unstall", 32'h14, 1'b1, 32'h14, 1'b1, 1'b0, 1'b0);
      applyStimulus();
      applyStimulus();
      applyStimulus();
      checkAll("seq20", 32'h20, 1'b1, 32'h20, 1'b1, 1'b0, 1'b0);

      // Taken branch to 0x200 costs one bubble
      branch_taken  = 1'b1;
      branch_target = 32'h200;
      applyStimulus();
      checkAll("branch", 32'h200, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0);
      branch_taken = 1'b0;
      applyStimulus();
      checkAll("brbubble", 32'h200, 1'b0, 32'h200, 1'b1, 1'b0, 1'b0);
      applyStimulus();
      checkAll("br204", 32'h204, 1'b1, 32'h204, 1'b1, 1'b0, 1'b0);

      // Exception beats jump and branch; misaligned jump target is ignored
      exception     = 1'b1;
      jump          = 1'b1;
      jump_target   = 32'h301;
      branch_taken  = 1'b1;
      branch_target = 32'h400;
      applyStimulus();
      checkAll("exc", 32'h80, 1'b1, 32'h80, 1'b0, 1'b1, 1'b0);
      exception    = 1'b0;
      jump         = 1'b0;
      branch_taken = 1'b0;
      applyStimulus();
      checkAll("excbubble", 32'h80, 1'b0, 32'h80, 1'b1, 1'b0, 1'b0);
      applyStimulus();
      checkAll("exc84", 32'h84, 1'b1, 32'h84, 1'b1, 1'b0, 1'b0);

      // Misaligned jump target is aligned and flagged for one cycle
      jump        = 1'b1;
      jump_target = 32'h303;
      applyStimulus();
      checkAll("jmis", 32'h300, 1'b1, 32'h300, 1'b0, 1'b1, 1'b1);
      jump = 1'b0;
      applyStimulus();
      checkAll("jmisend", 32'h300, 1'b0, 32'h300, 1'b1, 1'b0, 1'b0);

      // Redirect during FLUSH is accepted; stall during FLUSH is ignored
      jump        = 1'b1;
      jump_target = 32'h500;
      applyStimulus();
      checkAll("j500", 32'h500, 1'b1, 32'h500, 1'b0, 1'b1, 1'b0);
      jump          = 1'b0;
      branch_taken  = 1'b1;
      branch_target = 32'h602;
      applyStimulus();
      checkAll("flushredir", 32'h600, 1'b1, 32'h600, 1'b0, 1'b1, 1'b1);
      branch_taken = 1'b0;
      stall        = 1'b1;
      applyStimulus();
      checkAll("flushstall", 32'h600, 1'b0, 32'h600, 1'b1, 1'b0, 1'b0);
      applyStimulus();
      checkAll("stallafter", 32'h600, 1'b0, 32'h600, 1'b1, 1'b0, 1'b0);
      stall = 1'b0;
      applyStimulus();
      checkAll("s604", 32'h604, 1'b1, 32'h604, 1'b1, 1'b0, 1'b0);

      // Wrap-around at the top of the address space
      jump        = 1'b1;
      jump_target = 32'hFFFFFFFC;
      applyStimulus();
      checkAll("jtop", 32'hFFFFFFFC, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b1, 1'b0);
      jump = 1'b0;
      applyStimulus();
      checkAll("topbubble", 32'hFFFFFFFC, 1'b0, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0);
      applyStimulus();
      checkAll("wrap", 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);

      // Reset asserted while in FLUSH
      jump        = 1'b1;
      jump_target = 32'h700;
      applyStimulus();
      checkAll("j700", 32'h700, 1'b1, 32'h700, 1'b0, 1'b1, 1'b0);
      jump  = 1'b0;
      reset = 1'b1;
      applyStimulus();
      checkAll("rstflush", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      applyStimulus();
      checkAll("reinit", 32'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
      applyStimulus();
      checkAll("reseq4", 32'h4, 1'b1, 32'h4, 1'b1, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
